// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - glitch-filtered arm/entry-delay/alarm sequencer with siren timer and event counter
// Optional feature macro: ALARM_BLINK_EN (siren blinks with half-period BLINK_HALF while in ALARM)
module alarm_sequencer #(
    parameter int FILTER_LEN   = 2,
    parameter int DELAY_CYCLES = 8,
    parameter int SIREN_CYCLES = 32,
    parameter int CNT_W        = 8
`ifdef ALARM_BLINK_EN
    ,
    parameter int BLINK_HALF   = 4
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alarma_in,
    input  logic             arm,
    input  logic             disarm,
    output logic             siren,
    output logic             armed,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] event_count
);

    typedef enum logic [1:0] {
        S_DISARMED = 2'b00,
        S_ARMED    = 2'b01,
        S_ENTRY    = 2'b10,
        S_ALARM    = 2'b11
    } state_t;

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam int TW = (SIREN_CYCLES > 1) ? $clog2(SIREN_CYCLES) : 1;

    localparam logic [FW-1:0] FILT_MAX   = FW'(FILTER_LEN);
    localparam logic [DW-1:0] DELAY_LOAD = DW'(DELAY_CYCLES - 1);
    localparam logic [TW-1:0] SIREN_LOAD = TW'(SIREN_CYCLES - 1);

    state_t           r_state, w_state;
    logic [FW-1:0]    r_filt, w_filt, w_filt_inc;
    logic [DW-1:0]    r_delay, w_delay;
    logic [TW-1:0]    r_timer, w_timer;
    logic [CNT_W-1:0] r_count, w_count;
    logic             r_siren, w_siren;
    logic             r_armed;

`ifdef ALARM_BLINK_EN
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    logic [BW-1:0]    r_blink, w_blink;
`endif

    // Saturating increment of the run of consecutive high samples
    assign w_filt_inc = (r_filt == FILT_MAX) ? r_filt : r_filt + 1'b1;

    // Next-state and next-value logic; disarm outranks timer expiry and trigger
    always_comb begin
        w_state = r_state;
        w_filt  = '0;
        w_delay = r_delay;
        w_timer = r_timer;
        w_count = r_count;
        case (r_state)
            S_DISARMED: begin
                if (arm && !disarm) begin
                    w_state = S_ARMED;
                end
            end
            S_ARMED: begin
                if (disarm) begin
                    w_state = S_DISARMED;
                end else if (alarma_in) begin
                    if (w_filt_inc == FILT_MAX) begin
                        w_state = S_ENTRY;
                        w_delay = DELAY_LOAD;
                    end else begin
                        w_filt = w_filt_inc;
                    end
                end
            end
            S_ENTRY: begin
                if (disarm) begin
                    w_state = S_DISARMED;
                end else if (r_delay == '0) begin
                    w_state = S_ALARM;
                    w_timer = SIREN_LOAD;
                    if (r_count != '1) begin
                        w_count = r_count + 1'b1;
                    end
                end else begin
                    w_delay = r_delay - 1'b1;
                end
            end
            default: begin
                if (disarm) begin
                    w_state = S_DISARMED;
                end else if (r_timer == '0) begin
                    w_state = S_ARMED;
                end else begin
                    w_timer = r_timer - 1'b1;
                end
            end
        endcase

        w_siren = (w_state == S_ALARM);
`ifdef ALARM_BLINK_EN
        // Blink phase restarts high on every ALARM entry
        w_blink = '0;
        if (w_state == S_ALARM && r_state == S_ALARM) begin
            if (r_blink == BLINK_LAST) begin
                w_siren = !r_siren;
            end else begin
                w_blink = r_blink + 1'b1;
                w_siren = r_siren;
            end
        end
`endif
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_DISARMED;
            r_filt  <= '0;
            r_delay <= '0;
            r_timer <= '0;
            r_count <= '0;
            r_siren <= 1'b0;
            r_armed <= 1'b0;
`ifdef ALARM_BLINK_EN
            r_blink <= '0;
`endif
        end else begin
            r_state <= w_state;
            r_filt  <= w_filt;
            r_delay <= w_delay;
            r_timer <= w_timer;
            r_count <= w_count;
            r_siren <= w_siren;
            r_armed <= (w_state != S_DISARMED);
`ifdef ALARM_BLINK_EN
            r_blink <= w_blink;
`endif
        end
    end

    assign siren       = r_siren;
    assign armed       = r_armed;
    assign state       = r_state;
    assign event_count = r_count;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb/tb_alarm_sequencer.sv - randomized self-checking bench for alarm_sequencer against a behavioural model
module tb_alarm_sequencer;

    localparam int FL = 2;
    localparam int DC = 8;
    localparam int SC = 32;
    localparam int BH = 4;

    logic       clk = 1'b0;
    logic       reset, alarma_in, arm, disarm;
    logic       siren, armed;
    logic [1:0] state;
    logic [7:0] event_count;
    logic       siren2, armed2;
    logic [1:0] state2;
    logic [1:0] event_count2;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Behavioural model: mode, run length of highs, cycles spent in mode, alarms seen
    int m_mode    = 0;
    int m_run     = 0;
    int m_elapsed = 0;
    int m_events  = 0;

    int sat_exp [5] = '{1, 2, 3, 3, 3};

    alarm_sequencer #(.FILTER_LEN(FL), .DELAY_CYCLES(DC), .SIREN_CYCLES(SC), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .alarma_in(alarma_in), .arm(arm), .disarm(disarm),
        .siren(siren), .armed(armed), .state(state), .event_count(event_count)
    );

    alarm_sequencer #(.FILTER_LEN(FL), .DELAY_CYCLES(DC), .SIREN_CYCLES(SC), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .alarma_in(alarma_in), .arm(arm), .disarm(disarm),
        .siren(siren2), .armed(armed2), .state(state2), .event_count(event_count2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_siren();
        int s;
        s = (m_mode == 3) ? 1 : 0;
`ifdef ALARM_BLINK_EN
        if (((m_elapsed / BH) % 2) != 0) s = 0;
`endif
        return s;
    endfunction

    // Model advance on each rising edge
    always @(posedge clk) begin
        int nm;
        nm = m_mode;
        if (reset) begin
            m_mode = 0; m_run = 0; m_elapsed = 0; m_events = 0;
        end else begin
            if (disarm) begin
                nm = 0;
            end else begin
                case (m_mode)
                    0: if (arm) nm = 1;
                    1: begin
                        m_run = alarma_in ? m_run + 1 : 0;
                        if (m_run >= FL) nm = 2;
                    end
                    2: if (m_elapsed == DC - 1) begin nm = 3; m_events++; end
                    default: if (m_elapsed == SC - 1) nm = 1;
                endcase
            end
            if (nm != m_mode) begin
                m_mode = nm; m_elapsed = 0; m_run = 0;
            end else begin
                m_elapsed++;
            end
        end
    end

    // Compare process: both instances against the model every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("state", int'(state), m_mode);
            check("armed", int'(armed), (m_mode != 0) ? 1 : 0);
            check("siren", int'(siren), exp_siren());
            check("event_count", int'(event_count), (m_events > 255) ? 255 : m_events);
            check("state_w2", int'(state2), m_mode);
            check("siren_w2", int'(siren2), exp_siren());
            check("armed_w2", int'(armed2), (m_mode != 0) ? 1 : 0);
            check("event_count_w2", int'(event_count2), (m_events > 3) ? 3 : m_events);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic trigger();
        alarma_in = 1'b1;
        cyc();
        cyc();
        alarma_in = 1'b0;
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; disarm = 1'b0; alarma_in = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        chk_en = 1'b1;
        check("lit_reset_state", int'(state), 0);
        check("lit_reset_armed", int'(armed), 0);
        check("lit_reset_siren", int'(siren), 0);
        check("lit_reset_count", int'(event_count), 0);

        arm = 1'b1; cyc(); arm = 1'b0;
        check("lit_arm_state", int'(state), 1);
        check("lit_arm_armed", int'(armed), 1);

        alarma_in = 1'b1; cyc(); alarma_in = 1'b0; cyc(); cyc();
        check("lit_glitch_state", int'(state), 1);

        alarma_in = 1'b1; cyc();
        check("lit_first_high", int'(state), 1);
        cyc(); alarma_in = 1'b0;
        check("lit_entry", int'(state), 2);
        repeat (7) cyc();
        check("lit_entry_last", int'(state), 2);
        cyc();
        check("lit_alarm_state", int'(state), 3);
        check("lit_alarm_siren", int'(siren), 1);
        repeat (31) cyc();
        check("lit_alarm_last", int'(state), 3);
        cyc();
        check("lit_rearmed", int'(state), 1);
        check("lit_rearmed_siren", int'(siren), 0);
        check("lit_count1", int'(event_count), 1);

        trigger();
        repeat (3) cyc();
        disarm = 1'b1; cyc(); disarm = 1'b0;
        check("lit_entry_disarm_state", int'(state), 0);
        check("lit_entry_disarm_armed", int'(armed), 0);
        check("lit_entry_disarm_count", int'(event_count), 1);

        arm = 1'b1; cyc(); arm = 1'b0;
        trigger();
        repeat (17) cyc();
        check("lit_mid_alarm", int'(state), 3);
        reset = 1'b1; cyc(); reset = 1'b0;
        check("lit_mid_reset_state", int'(state), 0);
        check("lit_mid_reset_siren", int'(siren), 0);
        check("lit_mid_reset_count", int'(event_count), 0);

        arm = 1'b1; cyc(); arm = 1'b0;
        trigger();
        repeat (17) cyc();
        disarm = 1'b1; cyc(); disarm = 1'b0;
        check("lit_mid_disarm_state", int'(state), 0);
        check("lit_mid_disarm_siren", int'(siren), 0);
        check("lit_mid_disarm_count", int'(event_count), 1);

        reset = 1'b1; cyc(); reset = 1'b0;
        arm = 1'b1; cyc(); arm = 1'b0;
        for (int k = 0; k < 5; k++) begin
            trigger();
            repeat (8) cyc();
            check("lit_sat_count_w2", int'(event_count2), sat_exp[k]);
            check("lit_sat_count", int'(event_count), k + 1);
            repeat (32) cyc();
        end

        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            disarm    = ($urandom_range(0, 79) == 0);
            arm       = ($urandom_range(0, 5) == 0);
            alarma_in = ($urandom_range(0, 2) == 0);
            cyc();
        end
        reset = 1'b0; disarm = 1'b0; arm = 1'b0; alarma_in = 1'b0;
        cyc();
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
